mux_32_8: RTL and testbench



---
 rtl/mux_32_8.sv | 110 +++++++++++
 tb/tb_mux_32_8.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mux_32_8.sv
// mux_32_8: 32-bit to 8-bit serializer on clk_4f with a one-word pending buffer.
// A valid/ready handshake on the upstream side accepts words. Each accepted word
// is emitted as 4 consecutive bytes on data_out, with valid_out set.
// Optional build macro MUX_32_8_IDLE_COM_EN: when defined, idle and reset cycles
// drive COM_SYM on data_out instead of 8'h00.
module mux_32_8 #(
  parameter bit         MSB_FIRST = 1'b1,
  parameter logic [7:0] COM_SYM   = 8'hBC
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(3);

`ifdef MUX_32_8_IDLE_COM_EN
  localparam bit IDLE_COM = 1'b1;
`else
  localparam bit IDLE_COM = 1'b0;
`endif

  localparam logic [BYTE_W-1:0] IDLE_SYM = IDLE_COM ? COM_SYM : BYTE_W'(0);

  // IDLE corresponds to cur_v=0 and SEND to cur_v=1.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  cur;
  logic [WORD_W-1:0]  pend;
  logic               pend_v;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   byte_idx;
  logic [BYTE_W-1:0]  cur_byte;
  logic               accept;

  // The pending slot being empty is the only condition for taking a word.
  assign ready_out = !pend_v;
  assign accept    = valid_in && ready_out;

  // Select byte cnt of cur. The byte order follows MSB_FIRST.
  always_comb begin
    byte_idx = MSB_FIRST ? CNT_W'(LAST_BYTE - cnt) : cnt;
    cur_byte = '0;
    case (byte_idx)
      2'd0:    cur_byte = cur[7:0];
      2'd1:    cur_byte = cur[15:8];
      2'd2:    cur_byte = cur[23:16];
      default: cur_byte = cur[31:24];
    endcase
  end

  // Serializer FSM: load words, emit bytes, chain pending or new words with no bubble.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      cur       <= '0;
      pend      <= '0;
      pend_v    <= 1'b0;
      cnt       <= '0;
      data_out  <= IDLE_SYM;
      valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_out  <= IDLE_SYM;
          valid_out <= 1'b0;
          if (accept) begin
            cur   <= data_in;
            cnt   <= '0;
            state <= SEND;
          end
        end
        default: begin
          data_out  <= cur_byte;
          valid_out <= 1'b1;
          cnt       <= cnt + CNT_W'(1);
          if (cnt == LAST_BYTE) begin
            // An accept cannot happen while pend_v is set, so no word is lost here.
            if (pend_v) begin
              cur    <= pend;
              pend_v <= 1'b0;
              cnt    <= '0;
            end else if (accept) begin
              cur <= data_in;
              cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (accept) begin
            pend   <= data_in;
            pend_v <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_32_8.sv
// tb_mux_32_8: self-checking bench for mux_32_8.
// Two instances share the stimulus: one with MSB_FIRST=1 and one with MSB_FIRST=0.
// The reference model is a byte queue. Each accepted word appends its 4 bytes,
// and each clock pops one byte. The model expects ready while at most 4 bytes are
// outstanding.
module tb_mux_32_8;

`ifdef MUX_32_8_IDLE_COM_EN
  localparam logic [7:0] IDLE_SYM = 8'hBC;
`else
  localparam logic [7:0] IDLE_SYM = 8'h00;
`endif

  logic        clk_4f = 1'b0;
  logic        reset_L;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_m, ready_l;
  logic [7:0]  data_m, data_l;
  logic        valid_m, valid_l;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  q_msb[$];
  logic [7:0]  q_lsb[$];
  logic [31:0] tx_q[$];

  always #5 clk_4f = ~clk_4f;

  mux_32_8 #(.MSB_FIRST(1'b1)) dut_msb (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_m), .data_out(data_m), .valid_out(valid_m)
  );

  mux_32_8 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_l), .data_out(data_l), .valid_out(valid_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the idle output state of both instances.
  task automatic chk_idle(input string tag);
    chk({tag, "_valid_m"}, 32'(valid_m), 32'(0));
    chk({tag, "_data_m"},  32'(data_m),  32'(IDLE_SYM));
    chk({tag, "_valid_l"}, 32'(valid_l), 32'(0));
    chk({tag, "_data_l"},  32'(data_l),  32'(IDLE_SYM));
    chk({tag, "_ready_m"}, 32'(ready_m), 32'(1));
    chk({tag, "_ready_l"}, 32'(ready_l), 32'(1));
  endtask

  // Runs one clock with the given inputs and checks the handshake and the emitted byte.
  task automatic cycle(input logic v, input logic [31:0] d, output logic acc);
    logic       exp_rdy, ev;
    logic [7:0] em, el;
    valid_in = v;
    data_in  = d;
    exp_rdy  = (q_msb.size() <= 4);
    chk("ready_m", 32'(ready_m), 32'(exp_rdy));
    chk("ready_l", 32'(ready_l), 32'(exp_rdy));
    acc = v && exp_rdy;
    if (q_msb.size() > 0) begin
      ev = 1'b1;
      em = q_msb.pop_front();
      el = q_lsb.pop_front();
    end else begin
      ev = 1'b0;
      em = IDLE_SYM;
      el = IDLE_SYM;
    end
    if (acc) begin
      for (int b = 3; b >= 0; b--) q_msb.push_back(d[b*8 +: 8]);
      for (int b = 0; b < 4; b++)  q_lsb.push_back(d[b*8 +: 8]);
    end
    @(posedge clk_4f);
    #1;
    chk("valid_m", 32'(valid_m), 32'(ev));
    chk("data_m",  32'(data_m),  32'(em));
    chk("valid_l", 32'(valid_l), 32'(ev));
    chk("data_l",  32'(data_l),  32'(el));
  endtask

  // Offers the words in tx_q, holding each one until it is accepted, then drains the output.
  task automatic run_words(input bit gaps);
    logic acc, v;
    int   budget = 2000;
    while ((tx_q.size() > 0 || q_msb.size() > 0) && budget > 0) begin
      v = (tx_q.size() > 0) && (!gaps || $urandom_range(3) != 0);
      cycle(v, v ? tx_q[0] : $urandom, acc);
      if (acc) void'(tx_q.pop_front());
      budget--;
    end
    chk("drain_left", 32'(tx_q.size() + q_msb.size()), 32'(0));
  endtask

  initial begin
    logic acc;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;

    // Reset state.
    repeat (2) @(posedge clk_4f);
    #1;
    chk_idle("reset");
    reset_L = 1'b1;

    // Single word, then idle.
    tx_q.push_back(32'hEEFFFDCC);
    run_words(1'b0);
    repeat (2) cycle(1'b0, 32'h0, acc);

    // Two words back-to-back.
    tx_q.push_back(32'hEEFFFDCC);
    tx_q.push_back(32'hAA12BB00);
    run_words(1'b0);

    // Byte order, checked mainly on the LSB-first instance.
    tx_q.push_back(32'h11223344);
    run_words(1'b0);

    // Asynchronous reset in the middle of a word.
    cycle(1'b1, 32'hEEFFFDCC, acc);
    cycle(1'b0, 32'h0, acc);
    cycle(1'b0, 32'h0, acc);
    chk("mid_byte", 32'(data_m), 32'hFF);
    #2 reset_L = 1'b0;
    #1;
    chk_idle("midrst");
    q_msb.delete();
    q_lsb.delete();
    @(negedge clk_4f);
    reset_L = 1'b1;
    @(posedge clk_4f);
    #1;
    repeat (4) cycle(1'b0, 32'h0, acc);

    // Three held words: the third word stalls until the pending slot frees.
    tx_q.push_back(32'h01020304);
    tx_q.push_back(32'hA5B6C7D8);
    tx_q.push_back(32'hCAFEF00D);
    run_words(1'b0);

    // Random words with random valid gaps.
    for (int i = 0; i < 40; i++) tx_q.push_back($urandom);
    run_words(1'b1);
    repeat (2) cycle(1'b0, 32'h0, acc);
    chk_idle("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
